// File: rtl/pcg_wb_rng_if.sv
// Wishbone-classic slave bus plus valid/ready random-word stream for pcg_wb_rng.
interface pcg_wb_rng_if #(
  parameter int unsigned ADDR_W = 4
) ();
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_adr;
  logic [31:0]       wb_dat_w;
  logic [31:0]       wb_dat_r;
  logic              wb_ack;
  logic [31:0]       rng_data;
  logic              rng_valid;
  logic              rng_ready;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, rng_ready,
    input  wb_dat_r, wb_ack, rng_data, rng_valid
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, rng_ready,
    output wb_dat_r, wb_ack, rng_data, rng_valid
  );
endinterface

// File: rtl/pcg_wb_rng.sv
// PCG-family random generator with seeding FSM, software reseed, selectable output
// permutation and a 1-deep output buffer drained by a stream port or Wishbone OUT reads.
module pcg_wb_rng #(
  parameter int unsigned OUT_MODE     = 0,
  parameter int unsigned ADDR_W       = 4,
  parameter logic [63:0] MULT_DEFAULT = 64'h5851f42d4c957f2d,
  parameter logic [63:0] INC_DEFAULT  = 64'h14057b7ef767814f,
  parameter logic [63:0] SEED_DEFAULT = 64'h123456789abcdef0
) (
  input logic         clk,
  input logic         rst,
  pcg_wb_rng_if.slave bus
);

  typedef enum logic [1:0] {
    SEED_A,
    SEED_B,
    RUN
  } fsm_t;

  fsm_t state, state_nx;

  logic [63:0] st, seed, mult, inc;
  logic        enable;
  logic        valid_q;
  logic [31:0] data_q;
  logic [31:0] dat_r_q;
  logic        ack_q;

  logic [ADDR_W-1:0] adr;
  logic [31:0]       adr32;
  logic              ack_out;
  logic              req;
  logic              is_out_rd;
  logic              reg_acc;
  logic              stream_pop;
  logic              wb_pop;
  logic              consumed;
  logic              reseed;
  logic              gen_en;
  logic [63:0]       step_in;
  logic [63:0]       st_step;
  logic [31:0]       xsh;
  logic [63:0]       xsh_dbl;
  logic [31:0]       perm;
  logic [31:0]       rd_mux;

  assign bus.wb_dat_r  = dat_r_q;
  assign bus.wb_ack    = ack_out;
  assign bus.rng_data  = data_q;
  assign bus.rng_valid = valid_q;

  // Bus decode; the stream port wins a same-cycle pop, the pending OUT read waits a cycle.
  always_comb begin
    adr        = bus.wb_adr;
    adr32      = 32'(adr);
    ack_out    = ack_q & bus.wb_cyc;
    req        = bus.wb_cyc & bus.wb_stb & ~ack_out;
    is_out_rd  = (adr32 == 32'd0) & ~bus.wb_we;
    reg_acc    = req & ~is_out_rd;
    stream_pop = valid_q & bus.rng_ready;
    wb_pop     = req & is_out_rd & valid_q & ~stream_pop;
    consumed   = stream_pop | wb_pop;
    reseed     = reg_acc & bus.wb_we & (adr32 == 32'd7) & bus.wb_dat_w[1];
    gen_en     = (state == RUN) & enable;
  end

  // One shared multiplier: the step operand depends on which seeding phase is active.
  always_comb begin
    step_in = st;
    case (state)
      SEED_A:  step_in = '0;
      SEED_B:  step_in = st + seed;
      default: step_in = st;
    endcase
    st_step = step_in * mult + {inc[63:1], 1'b1};
  end

  always_comb begin
    xsh     = 32'(((st >> 18) ^ st) >> 27);
    xsh_dbl = {xsh, xsh} >> st[63:59];
    if (OUT_MODE == 1) begin
      perm = st[31:0] ^ {18'b0, st[63:50]};
    end else begin
      perm = xsh_dbl[31:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (adr32)
      32'd1:   rd_mux = seed[63:32];
      32'd2:   rd_mux = seed[31:0];
      32'd3:   rd_mux = mult[63:32];
      32'd4:   rd_mux = mult[31:0];
      32'd5:   rd_mux = inc[63:32];
      32'd6:   rd_mux = inc[31:0];
      32'd7:   rd_mux = {30'b0, enable, 1'b0};
      32'd8:   rd_mux = {29'b0, state == RUN, enable, valid_q};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      SEED_A:  state_nx = SEED_B;
      SEED_B:  state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = SEED_A;
    endcase
    if (reseed) begin
      state_nx = SEED_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED_A;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= '0;
      seed    <= SEED_DEFAULT;
      mult    <= MULT_DEFAULT;
      inc     <= INC_DEFAULT;
      enable  <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      dat_r_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (wb_pop) begin
        ack_q   <= 1'b1;
        dat_r_q <= data_q;
      end else if (reg_acc) begin
        ack_q <= 1'b1;
        if (!bus.wb_we) begin
          dat_r_q <= rd_mux;
        end else begin
          case (adr32)
            32'd1:   seed[63:32] <= bus.wb_dat_w;
            32'd2:   seed[31:0]  <= bus.wb_dat_w;
            32'd3:   mult[63:32] <= bus.wb_dat_w;
            32'd4:   mult[31:0]  <= bus.wb_dat_w;
            32'd5:   inc[63:32]  <= bus.wb_dat_w;
            32'd6:   inc[31:0]   <= bus.wb_dat_w;
            32'd7:   enable      <= bus.wb_dat_w[0];
            default: ;
          endcase
        end
      end

      if (state != RUN) begin
        st <= st_step;
      end else if (gen_en && (!valid_q || consumed)) begin
        st <= st_step;
      end

      // The buffered word is taken from the pre-step state.
      if (reseed) begin
        valid_q <= 1'b0;
      end else if (gen_en && (!valid_q || consumed)) begin
        data_q  <= perm;
        valid_q <= 1'b1;
      end else if (consumed) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
